ppi_mode1_peripheral: RTL

- Peripheral-side handshake engine for an 8255A port group running in mode 1 (strobed I/O); it is the device at the far end of a port.
- Transmit path sources bytes into an 8255 input port using STB_n and watches IBF.
- Receive path sinks bytes from an 8255 output port by watching OBF_n and answering with ACK_n.
- Sits between a local byte-stream interface (valid/ready) and the 8255 port/PortC pins; used as the bench device model and as the real peripheral adapter.

---
 rtl/ppi_pkg.sv | 26 ++
 rtl/ppi_sync2.sv | 21 ++
 rtl/ppi_mode1_peripheral.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ppi_pkg.sv
// Shared constants for the 8255A mode-1 peripheral: FSM encodings, mode codes
// and the port-B PortC handshake bit positions.
package ppi_pkg;

  localparam logic [2:0] TX_IDLE     = 3'd0;
  localparam logic [2:0] TX_SETUP    = 3'd1;
  localparam logic [2:0] TX_STROBE   = 3'd2;
  localparam logic [2:0] TX_WAIT_IBF = 3'd3;
  localparam logic [2:0] TX_WAIT_CLR = 3'd4;

  localparam logic [1:0] RX_IDLE     = 2'd0;
  localparam logic [1:0] RX_ACK      = 2'd1;
  localparam logic [1:0] RX_WAIT_OBF = 2'd2;

  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;

  // Port B handshake lines live in PC0..PC2
  localparam int PCB_INTR  = 0;
  localparam int PCB_IBF   = 1;
  localparam int PCB_OBF_N = 1;
  localparam int PCB_STB_N = 2;
  localparam int PCB_ACK_N = 2;

endpackage

// File: rtl/ppi_sync2.sv
// Two-flop synchronizer for a single asynchronous level; RST_VAL sets the
// value both flops take while reset is asserted.
module ppi_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {2{RST_VAL}};
    else        sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/ppi_mode1_peripheral.sv
// Far-end device for an 8255A mode-1 port group: strobes bytes into an input
// port (STB_n/IBF) and acknowledges bytes from an output port (OBF_n/ACK_n).
module ppi_mode1_peripheral
  import ppi_pkg::*;
#(
  parameter int STB_CYCLES = 2,
  parameter int ACK_CYCLES = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] port_out,
  output logic       stb_n,
  input  logic       ibf,
  input  logic [7:0] port_in,
  input  logic       obf_n,
  output logic       ack_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       err_timeout
);

  localparam int SW = $clog2(STB_CYCLES + 1);
  localparam int AW = $clog2(ACK_CYCLES + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STB_LAST = SW'(STB_CYCLES - 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic          TMO_EN   = (TIMEOUT != 0);

  logic ibf_s, obf_n_s, obf_s;

  ppi_sync2 #(.RST_VAL(1'b0)) u_sync_ibf (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ibf),
    .q_o   (ibf_s)
  );

  ppi_sync2 #(.RST_VAL(1'b1)) u_sync_obf (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (obf_n),
    .q_o   (obf_n_s)
  );

  assign obf_s = !obf_n_s;

  // Holds tx_ready low while reset is asserted and for the first edge after
  logic run_q;

  logic [2:0]    tx_state_q, tx_state_d;
  logic [SW-1:0] stb_cnt_q,  stb_cnt_d;
  logic [TW-1:0] tx_tmo_q,   tx_tmo_d;
  logic [7:0]    port_out_q, port_out_d;
  logic          tx_tmo_err, tx_tmo_hit;

  logic [1:0]    rx_state_q, rx_state_d;
  logic [AW-1:0] ack_cnt_q,  ack_cnt_d;
  logic [TW-1:0] rx_tmo_q,   rx_tmo_d;
  logic [7:0]    rx_data_q,  rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_tmo_err, rx_tmo_hit;

  logic          err_q, err_d;

  assign tx_tmo_hit = TMO_EN && (tx_tmo_q == TMO_LAST);
  assign rx_tmo_hit = TMO_EN && (rx_tmo_q == TMO_LAST);

  assign tx_ready    = run_q && (tx_state_q == TX_IDLE) && !ibf_s;
  assign stb_n       = (tx_state_q != TX_STROBE);
  assign ack_n       = (rx_state_q != RX_ACK);
  assign port_out    = port_out_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign err_timeout = err_q;

  always_comb begin
    tx_state_d = tx_state_q;
    stb_cnt_d  = stb_cnt_q;
    tx_tmo_d   = tx_tmo_q;
    port_out_d = port_out_q;
    tx_tmo_err = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid && tx_ready) begin
          port_out_d = tx_data;
          tx_state_d = TX_SETUP;
        end
      end
      TX_SETUP: begin
        stb_cnt_d  = '0;
        tx_state_d = TX_STROBE;
      end
      TX_STROBE: begin
        if (stb_cnt_q == STB_LAST) begin
          tx_tmo_d   = '0;
          tx_state_d = TX_WAIT_IBF;
        end else begin
          stb_cnt_d = stb_cnt_q + 1'b1;
        end
      end
      TX_WAIT_IBF: begin
        if (ibf_s) begin
          tx_tmo_d   = '0;
          tx_state_d = TX_WAIT_CLR;
        end else if (tx_tmo_hit) begin
          tx_tmo_err = 1'b1;
          tx_state_d = TX_IDLE;
        end else begin
          tx_tmo_d = tx_tmo_q + 1'b1;
        end
      end
      TX_WAIT_CLR: begin
        if (!ibf_s) begin
          tx_state_d = TX_IDLE;
        end else if (tx_tmo_hit) begin
          tx_tmo_err = 1'b1;
          tx_state_d = TX_IDLE;
        end else begin
          tx_tmo_d = tx_tmo_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Capture needs rx_valid low, so a consume and a capture never coincide
  always_comb begin
    rx_state_d = rx_state_q;
    ack_cnt_d  = ack_cnt_q;
    rx_tmo_d   = rx_tmo_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_tmo_err = 1'b0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (obf_s && !rx_valid_q) begin
          ack_cnt_d  = '0;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK: begin
        if (ack_cnt_q == ACK_LAST) begin
          rx_data_d  = port_in;
          rx_valid_d = 1'b1;
          rx_tmo_d   = '0;
          rx_state_d = RX_WAIT_OBF;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      RX_WAIT_OBF: begin
        if (!obf_s) begin
          rx_state_d = RX_IDLE;
        end else if (rx_tmo_hit) begin
          rx_tmo_err = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          rx_tmo_d = rx_tmo_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign err_d = err_q | tx_tmo_err | rx_tmo_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      stb_cnt_q  <= '0;
      tx_tmo_q   <= '0;
      port_out_q <= 8'h00;
      rx_state_q <= RX_IDLE;
      ack_cnt_q  <= '0;
      rx_tmo_q   <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      tx_state_q <= tx_state_d;
      stb_cnt_q  <= stb_cnt_d;
      tx_tmo_q   <= tx_tmo_d;
      port_out_q <= port_out_d;
      rx_state_q <= rx_state_d;
      ack_cnt_q  <= ack_cnt_d;
      rx_tmo_q   <= rx_tmo_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end

endmodule
